// File: rtl/prog_mem_loader_pkg.sv
// Shared types and width helpers for the picoMIPS program loader.
// The loader and its instruction packer both import this package.
package prog_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_FILL    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_e;

    function automatic int instr_width(input int opcode_w, input int reg_addr_w, input int prog_addr_w);
        return opcode_w + 2 * reg_addr_w + prog_addr_w;
    endfunction

    function automatic int bytes_per_word(input int instr_w, input int byte_w);
        return (instr_w + byte_w - 1) / byte_w;
    endfunction

    function automatic int idx_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_loader_instr_packer.sv
// Assembles stream bytes (MSB byte first) into one instruction word.
// Only the low INSTR_W bits survive, so excess high bits of the first byte fall away.
module prog_mem_loader_instr_packer
    import prog_mem_loader_pkg::*;
#(
    parameter int INSTR_W = 12,
    parameter int BYTE_W  = 8,
    parameter int BPW     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               accept,
    input  logic               in_last,
    output logic [INSTR_W-1:0] packed_word,
    output logic               word_complete,
    output logic               partial_last
);

    localparam int IDX_W = idx_width(BPW);

    logic [INSTR_W-1:0] shift_q;
    logic [INSTR_W-1:0] shift_d;
    logic [INSTR_W-1:0] shift_next_s;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [IDX_W-1:0]   byte_idx_d;
    logic               at_final_s;

    assign shift_next_s  = INSTR_W'({shift_q, in_data});
    assign at_final_s    = (byte_idx_q == IDX_W'(BPW - 1));
    assign packed_word   = shift_next_s;
    assign word_complete = accept && at_final_s;
    assign partial_last  = accept && in_last && !at_final_s;

    // Shift and byte-index update; a partial last byte also rewinds the index.
    always_comb begin
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (accept) begin
            shift_d = shift_next_s;
            if (at_final_s || in_last) begin
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
            end
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Fills picoMIPS program memory from a byte stream, optionally zero-fills the tail,
// and holds the core in reset until the whole image has been written.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int OPCODE_W    = 1,
    parameter int REG_ADDR_W  = 3,
    parameter int PROG_ADDR_W = 5,
    parameter int BYTE_W      = 8,
    parameter int ZERO_FILL   = 1,
    localparam int INSTR_W    = instr_width(OPCODE_W, REG_ADDR_W, PROG_ADDR_W),
    localparam int BPW        = bytes_per_word(INSTR_W, BYTE_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   load_start,
    output logic                   mem_we,
    output logic [PROG_ADDR_W-1:0] mem_addr,
    output logic [INSTR_W-1:0]     mem_wdata,
    output logic                   core_reset,
    output logic                   done,
    output logic                   err,
    output logic [PROG_ADDR_W:0]   word_count
);

    localparam logic [PROG_ADDR_W-1:0] LAST_ADDR = {PROG_ADDR_W{1'b1}};

    loader_state_e          state_q, state_d;
    logic [PROG_ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [PROG_ADDR_W:0]   word_count_q, word_count_d;
    logic                   last_q, last_d;
    logic                   mem_we_q, mem_we_d;
    logic [PROG_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                   core_reset_q, core_reset_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   accept_s;
    logic                   restart_s;
    logic                   word_complete_s;
    logic                   partial_last_s;
    logic [INSTR_W-1:0]     packed_word_s;

    assign in_ready   = (state_q == ST_LOAD) && !reset;
    assign accept_s   = in_valid && in_ready;
    assign restart_s  = load_start && ((state_q == ST_RUN) || (state_q == ST_ERROR));

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

    prog_mem_loader_instr_packer #(
        .INSTR_W (INSTR_W),
        .BYTE_W  (BYTE_W),
        .BPW     (BPW)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (restart_s),
        .in_data       (in_data),
        .accept        (accept_s),
        .in_last       (in_last),
        .packed_word   (packed_word_s),
        .word_complete (word_complete_s),
        .partial_last  (partial_last_s)
    );

    // State register plus datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            word_ptr_q   <= '0;
            word_count_q <= '0;
            last_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            word_count_q <= word_count_d;
            last_q       <= last_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and pointer/counter logic.
    always_comb begin
        state_d      = state_q;
        word_ptr_d   = word_ptr_q;
        word_count_d = word_count_q;
        last_d       = last_q;
        case (state_q)
            ST_LOAD: begin
                if (partial_last_s) begin
                    state_d = ST_ERROR;
                end else if (word_complete_s) begin
                    state_d = ST_WRITE;
                    last_d  = in_last;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                word_count_d = word_count_q + {{PROG_ADDR_W{1'b0}}, 1'b1};
                if (last_q) begin
                    if ((ZERO_FILL != 0) && (word_ptr_q != LAST_ADDR)) begin
                        state_d    = ST_FILL;
                        word_ptr_d = word_ptr_q + {{(PROG_ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else if (word_ptr_q == LAST_ADDR) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d    = ST_LOAD;
                    word_ptr_d = word_ptr_q + {{(PROG_ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FILL: begin
                if (word_ptr_q == LAST_ADDR) begin
                    state_d = ST_RELEASE;
                end else begin
                    word_ptr_d = word_ptr_q + {{(PROG_ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_ERROR: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    word_ptr_d   = '0;
                    word_count_d = '0;
                    last_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                // An illegal encoding parks the loader where the core stays in reset.
                state_d = ST_ERROR;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mem_we_d     = 1'b0;
        mem_addr_d   = word_ptr_d;
        mem_wdata_d  = '0;
        core_reset_d = 1'b1;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_d)
            ST_WRITE: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = packed_word_s;
            end
            ST_FILL: begin
                mem_we_d = 1'b1;
            end
            ST_RUN: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            ST_LOAD, ST_RELEASE: begin
                mem_we_d = 1'b0;
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader with default parameters (12-bit words, 2 bytes each).
module tb_prog_mem_loader;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [11:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        load_start;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;
    logic [5:0]  word_count;

    vec_t        tbl [8];
    wr_t         exp_q [$];
    logic [4:0]  obs_addr [512];
    logic [11:0] obs_data [512];
    int          obs_n = 0;
    int          rd_idx = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    prog_mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .load_start (load_start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every memory write for the scoreboard.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && obs_n < 512) begin
            obs_addr[obs_n] <= mem_addr;
            obs_data[obs_n] <= mem_wdata;
            obs_n           <= obs_n + 1;
            last_we_cyc     <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [11:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_fill(input int from);
        for (int a = from; a < 32; a++) expect_wr(5'(a), 12'h000);
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        logic ok;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        chk("handshake", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic l, input int gap);
        send_byte(b0, 1'b0, gap);
        send_byte(b1, l, gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // which: 0 = done, 1 = err, 2 = core_reset low. Leaves at negedge where seen.
    task automatic wait_for(input int which, input string nm);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            case (which)
                0: hit = (done === 1'b1);
                1: hit = (err === 1'b1);
                default: hit = (core_reset === 1'b0);
            endcase
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic finish_sb(input string nm);
        wr_t e;
        @(posedge clk); #1;
        while (rd_idx < obs_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({nm, "_addr"}, 32'(obs_addr[rd_idx]), 32'(e.a));
            chk({nm, "_data"}, 32'(obs_data[rd_idx]), 32'(e.d));
            rd_idx = rd_idx + 1;
        end
        chk({nm, "_extra_writes"}, 32'(obs_n - rd_idx), 32'd0);
        chk({nm, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        rd_idx = obs_n;
        exp_q.delete();
    endtask

    initial begin
        int fall_gap;
        logic [7:0] b0;
        logic [7:0] b1;

        tbl[0] = '{8'h01, 8'h23, 12'h123};
        tbl[1] = '{8'h0F, 8'hFF, 12'hFFF};
        tbl[2] = '{8'hF1, 8'h23, 12'h123};
        tbl[3] = '{8'hAB, 8'hCD, 12'hBCD};
        tbl[4] = '{8'h00, 8'h00, 12'h000};
        tbl[5] = '{8'h80, 8'h01, 12'h001};
        tbl[6] = '{8'h7E, 8'h5A, 12'hE5A};
        tbl[7] = '{8'hFF, 8'h00, 12'hF00};

        reset      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        load_start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Test 1: two words then zero fill; core_reset falls 2 cycles after last write
        expect_wr(5'd0, tbl[0].exp);
        expect_wr(5'd1, tbl[1].exp);
        expect_fill(2);
        send_word(tbl[0].b0, tbl[0].b1, 1'b0, 0);
        send_word(tbl[1].b0, tbl[1].b1, 1'b1, 0);
        wait_for(2, "t1_core_release");
        fall_gap = cyc - last_we_cyc;
        chk("t1_release_gap", 32'(fall_gap), 32'd2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_word_count", 32'(word_count), 32'd2);
        chk("t1_err", 32'(err), 32'd0);
        finish_sb("t1");

        // Test 2: high nibble of first byte ignored
        do_reset();
        expect_wr(5'd0, tbl[2].exp);
        expect_fill(1);
        send_word(tbl[2].b0, tbl[2].b1, 1'b1, 0);
        wait_for(0, "t2_done");
        chk("t2_word_count", 32'(word_count), 32'd1);
        finish_sb("t2");

        // Test 3: in_last on first byte of a word
        do_reset();
        send_byte(8'h55, 1'b1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_core_reset", 32'(core_reset), 32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        pulse_load_start();
        @(negedge clk);
        chk("t3_restart_in_ready", 32'(in_ready), 32'd1);
        chk("t3_restart_err", 32'(err), 32'd0);
        chk("t3_restart_count", 32'(word_count), 32'd0);
        finish_sb("t3");

        // Test 4a: 32 words without in_last overflow into error
        for (int i = 0; i < 32; i++) begin
            b0 = 8'(i * 7 + 3);
            b1 = 8'(i * 29 + 1);
            expect_wr(5'(i), {b0[3:0], b1});
            send_word(b0, b1, 1'b0, 0);
        end
        wait_for(1, "t4_overflow_err");
        chk("t4_overflow_done", 32'(done), 32'd0);
        chk("t4_overflow_core_reset", 32'(core_reset), 32'd1);
        @(posedge clk); #1;
        finish_sb("t4a");

        // Test 4b: exactly 32 words with in_last, no fill
        pulse_load_start();
        for (int i = 0; i < 32; i++) begin
            b0 = 8'(i * 11 + 9);
            b1 = 8'(i ^ 8'hA5);
            expect_wr(5'(i), {b0[3:0], b1});
            send_word(b0, b1, (i == 31), 0);
        end
        wait_for(0, "t4_full_done");
        chk("t4_full_word_count", 32'(word_count), 32'd32);
        chk("t4_full_err", 32'(err), 32'd0);
        finish_sb("t4b");

        // Test 5: reset mid-load discards partial word
        do_reset();
        expect_wr(5'd0, tbl[3].exp);
        send_word(tbl[3].b0, tbl[3].b1, 1'b0, 0);
        send_byte(8'h77, 1'b0, 0);
        do_reset();
        finish_sb("t5a");
        expect_wr(5'd0, tbl[5].exp);
        expect_fill(1);
        send_word(tbl[5].b0, tbl[5].b1, 1'b1, 0);
        wait_for(0, "t5_done");
        chk("t5_word_count", 32'(word_count), 32'd1);
        finish_sb("t5b");

        // Test 6: reload from RUN with random in_valid gaps
        pulse_load_start();
        @(negedge clk);
        chk("t6_core_reset", 32'(core_reset), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_word_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) expect_wr(5'(i), tbl[i].exp);
        expect_fill(8);
        for (int i = 0; i < 8; i++) begin
            send_word(tbl[i].b0, tbl[i].b1, (i == 7), int'($urandom_range(3, 0)));
        end
        wait_for(0, "t6_done_after_reload");
        chk("t6_final_word_count", 32'(word_count), 32'd8);
        chk("t6_final_core_reset", 32'(core_reset), 32'd0);
        finish_sb("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised program loader that fills picoMIPS program memory from a byte stream, replacing hierarchical memory preload. Packs bytes into instructions of configurable width and writes them at incrementing addresses. Optionally zero-fills unused locations. Holds the core in reset until the program is complete, and supports reload while running.

Parameters:
OPCODE_W, 1, opcode field width
REG_ADDR_W, 3, width of each register-address field
PROG_ADDR_W, 5, program memory address width; DEPTH = 2**PROG_ADDR_W
BYTE_W, 8, stream data width
ZERO_FILL, 1, 1 = write zero to every location after the last program word
(derived) INSTR_W = OPCODE_W + 2*REG_ADDR_W + PROG_ADDR_W (12 by default); BPW = ceil(INSTR_W/BYTE_W) (2 by default)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_data  in  BYTE_W  stream byte, MSB byte of each word first
in_valid  in  1  in_data valid
in_last  in  1  qualifies the final byte of the program
in_ready  out  1  loader accepts a byte; transfer occurs when in_valid & in_ready
load_start  in  1  single-cycle request to reload, honoured in RUN or ERROR
mem_we  out  1  program memory write strobe
mem_addr  out  PROG_ADDR_W  write address
mem_wdata  out  INSTR_W  write data
core_reset  out  1  reset to the picoMIPS core
done  out  1  program loaded, core running
err  out  1  load failed
word_count  out  PROG_ADDR_W+1  program words written, fill writes excluded

Behaviour:
- Only clk and synchronous active-high reset are used. While reset is high at an edge:
  - state <= LOAD; byte_idx, word_ptr, word_count <= 0; mem_we, done, err <= 0; core_reset <= 1.
  - in_ready is forced to 0 while reset is high.
- Reset mid-load discards any partial word. The next accepted byte starts a word at address 0.
- LOAD:
  - in_ready = 1. Each handshake shifts in_data into the shift register; byte_idx increments.
  - The assembled word is the low INSTR_W bits of the concatenated BPW bytes. Excess high bits of the first byte are ignored.
  - On handshake with byte_idx = BPW-1 -> WRITE. The last flag is captured.
  - in_last on a handshake with byte_idx < BPW-1 -> ERROR; nothing is written.
- WRITE (one cycle):
  - in_ready = 0; mem_we = 1, mem_addr = word_ptr, mem_wdata = packed word. All three are registered, so they appear the cycle after the final byte handshake.
  - word_count increments.
  - Next state:
    - last set and ZERO_FILL and word_ptr < DEPTH-1 -> FILL
    - last set otherwise -> RELEASE
    - last clear and word_ptr = DEPTH-1 -> ERROR (overflow)
    - otherwise word_ptr++ and -> LOAD
- FILL: one write per cycle with mem_wdata = 0, at addresses word_ptr+1 through DEPTH-1. After writing address DEPTH-1 -> RELEASE.
- RELEASE (one cycle): mem_we = 0, core_reset = 1. -> RUN.
- RUN:
  - core_reset = 0, done = 1, in_ready = 0; stream input is ignored.
  - load_start -> LOAD. core_reset = 1 and done = 0 from the next cycle; word_ptr, word_count and byte_idx are cleared.
- ERROR:
  - err = 1, core_reset = 1, in_ready = 0.
  - load_start -> LOAD with counters cleared and err cleared.
- Throughput: one word per BPW+1 cycles with in_valid held high. in_valid gaps stall without loss.
- load_start in LOAD, WRITE, FILL or RELEASE is ignored.
- core_reset never deasserts before the last write (program or fill) has completed.

Decomposition:
- Shared constants: add INSTR_W/BPW field-width macros beside the existing size macros in constants.sv.
- New package loader_pkg: state enum typedef {LOAD, WRITE, FILL, RELEASE, RUN, ERROR}.
- Sub-module instr_packer: shift register plus byte_idx counter. Outputs packed word and word_complete; flags a partial word on in_last.

Test Plan:
1. Defaults, ZERO_FILL=1. Bytes 0x01,0x23,0x0F,0xFF(last) -> writes [0]=0x123, [1]=0xFFF, then [2..31]=0. core_reset falls 2 cycles after the [31] write; word_count=2, done=1.
2. Bytes 0xF1,0x23(last) -> [0]=0x123; the high nibble of the first byte is ignored.
3. in_last on the first byte of a word -> no mem_we, err=1, core_reset stays 1. Then load_start -> in_ready=1 next cycle.
4. 32 words with no in_last -> 32 writes, then err=1. Repeat with in_last on the 32nd byte pair -> done=1, no fill writes, word_count=32.
5. Assert reset after 3 bytes -> next 2-byte word written at addr 0, word_count=1.
6. In RUN: pulse load_start -> core_reset=1 next cycle. Reload with random in_valid gaps; the image matches the stream exactly.
